// File: rtl/connect4_auto_player.sv
// connect4_auto_player: plays one Connect 4 side through the col_sel/press_n button interface.
// Optional: define AUTOPLAYER_CENTER_FIRST_EN to always start the column scan at the center (3).
module connect4_auto_player #(
    parameter logic [1:0] AI_PLAYER   = 2'd2,
    parameter int         THINK_CYC   = 16,
    parameter int         PULSE_CYC   = 4,
    parameter int         ACK_TIMEOUT = 64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] jugador_actual,
    input  logic       hay_ganador,
    input  logic [6:0] col_full,
    output logic [2:0] col_sel,
    output logic       press_n,
    output logic       busy,
    output logic       no_move,
    output logic       timeout_err
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        THINK,
        SCAN,
        PRESS,
        WAIT_ACK,
        DONE
    } state_t;

    state_t        state;
    state_t        next;
    logic [7:0]    lfsr;
    logic          lfsr_fb;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic [2:0]    scan_col;
    logic [2:0]    scan_cnt;
    logic [2:0]    start_col;
    logic [2:0]    scan_inc;
    logic          my_turn;
    logic          cur_full;

    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign cnt_zero = (cnt == '0);
    assign my_turn  = enable && (jugador_actual == AI_PLAYER);
    assign cur_full = col_full[scan_col];
    assign scan_inc = (scan_col == 3'd6) ? 3'd0 : scan_col + 3'd1;

`ifdef AUTOPLAYER_CENTER_FIRST_EN
    assign start_col = 3'd3;
`else
    assign start_col = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        if (hay_ganador) begin
            next = DONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (my_turn) next = THINK;
                end
                THINK: begin
                    if (!my_turn)      next = IDLE;
                    else if (cnt_zero) next = SCAN;
                end
                SCAN: begin
                    if (!my_turn)               next = IDLE;
                    else if (!cur_full)         next = PRESS;
                    else if (scan_cnt == 3'd6)  next = DONE;
                end
                PRESS: begin
                    if (cnt_zero) next = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (jugador_actual != AI_PLAYER) next = IDLE;
                    else if (cnt_zero)               next = IDLE;
                end
                DONE:    next = DONE;
                default: next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        press_n = 1'b1;
        unique case (state)
            THINK, SCAN, WAIT_ACK: busy = 1'b1;
            PRESS: begin
                busy    = 1'b1;
                press_n = hay_ganador;
            end
            default: ;
        endcase
    end

    // Datapath: shared down-counter, scan pointer, move latch and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr        <= LFSR_SEED;
            cnt         <= '0;
            scan_col    <= 3'd0;
            scan_cnt    <= 3'd0;
            col_sel     <= 3'd0;
            no_move     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            unique case (state)
                IDLE: begin
                    cnt <= CW'(THINK_CYC - 1);
                end
                THINK: begin
                    cnt      <= cnt - 1'b1;
                    scan_col <= start_col;
                    scan_cnt <= 3'd0;
                end
                SCAN: begin
                    scan_col <= scan_inc;
                    scan_cnt <= scan_cnt + 3'd1;
                    if (next == PRESS) begin
                        col_sel <= scan_col;
                        cnt     <= CW'(PULSE_CYC - 1);
                    end else if (next == DONE && !hay_ganador) begin
                        no_move <= 1'b1;
                    end
                end
                PRESS: begin
                    if (cnt_zero) cnt <= CW'(ACK_TIMEOUT - 1);
                    else          cnt <= cnt - 1'b1;
                end
                WAIT_ACK: begin
                    cnt <= cnt - 1'b1;
                    if (!hay_ganador && cnt_zero &&
                        jugador_actual == AI_PLAYER) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_auto_player.sv
// tb_connect4_auto_player: directed table-driven bench for connect4_auto_player.
// Honors AUTOPLAYER_CENTER_FIRST_EN when compiled with it.
module tb_connect4_auto_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] jugador_actual = 2'd1;
    logic       hay_ganador = 1'b0;
    logic [6:0] col_full = '0;
    logic [2:0] col_sel;
    logic       press_n;
    logic       busy;
    logic       no_move;
    logic       timeout_err;
    logic [7:0] m_lfsr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] cf;
        int         start;
        int         exp_col;
        int         exp_lat;
    } vec_t;

`ifdef AUTOPLAYER_CENTER_FIRST_EN
    localparam int NV = 4;
    localparam int EXP0 = 3;
`else
    localparam int NV = 6;
    localparam int EXP0 = 4;
`endif

    vec_t tbl[NV];

    connect4_auto_player dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .jugador_actual (jugador_actual),
        .hay_ganador    (hay_ganador),
        .col_full       (col_full),
        .col_sel        (col_sel),
        .press_n        (press_n),
        .busy           (busy),
        .no_move        (no_move),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, free running out of reset
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [7:0] adv(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        return r;
    endfunction

    // Start column if the turn begins in the current cycle (16 THINK cycles ahead)
    function automatic int predict(input logic [7:0] v);
        logic [7:0] r;
        logic [2:0] c;
        r = adv(v, 16);
        c = (r[2:0] == 3'd7) ? 3'd0 : r[2:0];
`ifdef AUTOPLAYER_CENTER_FIRST_EN
        c = 3'd3;
`endif
        return int'(c);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] cf, input logic go);
        rst = 1'b1;
        enable = 1'b1;
        hay_ganador = 1'b0;
        jugador_actual = 2'd1;
        col_full = cf;
        tick;
        tick;
        rst = 1'b0;
        if (go) jugador_actual = 2'd2;
    endtask

    task automatic wait_press(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (press_n && n < 100);
        if (press_n) n = -1;
    endtask

    task automatic pulse_len(output int m);
        m = 1;
        while (!press_n && m < 50) begin
            tick;
            if (!press_n) m++;
        end
    endtask

    task automatic force_start(input int s);
        int k;
        k = 0;
        while (predict(m_lfsr) != s && k < 300) begin
            tick;
            k++;
        end
        chk("force_start", predict(m_lfsr), s);
        jugador_actual = 2'd2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        int flag;
        int exp2;

`ifdef AUTOPLAYER_CENTER_FIRST_EN
        tbl[0] = '{7'b0001000, -1, 4, 19};
        tbl[1] = '{7'b0000000, -1, 3, 18};
        tbl[2] = '{7'b1111000, -1, 0, 22};
        tbl[3] = '{7'b0111111, -1, 6, 21};
`else
        tbl[0] = '{7'b0000000, -1, 4, 18};
        tbl[1] = '{7'b1100000,  5, 0, 20};
        tbl[2] = '{7'b0000100,  2, 3, 19};
        tbl[3] = '{7'b1000000,  6, 0, 19};
        tbl[4] = '{7'b1111110,  1, 0, 24};
        tbl[5] = '{7'b0001000,  3, 4, 19};
`endif

        // Reset state, busy latency, first move, then ack timeout and retry
        rst = 1'b1;
        enable = 1'b1;
        jugador_actual = 2'd2;
        col_full = '0;
        tick;
        chk("reset_outputs", int'({col_sel, press_n, busy, no_move, timeout_err}),
            int'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        tick;
        chk("busy_rise", int'(busy), 1);
        wait_press(n);
        chk("first_latency", n, 17);
        chk("first_col", int'(col_sel), EXP0);
        pulse_len(m);
        chk("first_pulse", m, 4);
        flag = 0;
        for (int i = 0; i < 63; i++) begin
            tick;
            if (timeout_err || !press_n) flag = 1;
        end
        chk("timeout_early", flag, 0);
        tick;
        chk("timeout_err", int'({timeout_err, busy}), 2);
        exp2 = predict(m_lfsr);
        wait_press(n);
        chk("retry_latency", n, 18);
        chk("retry_col", int'(col_sel), exp2);
        chk("timeout_sticky", int'(timeout_err), 1);

        // Table of scan patterns with full handshake
        for (int i = 0; i < NV; i++) begin
            do_reset(tbl[i].cf, tbl[i].start < 0);
            if (tbl[i].start >= 0) force_start(tbl[i].start);
            wait_press(n);
            chk($sformatf("latency[%0d]", i), n, tbl[i].exp_lat);
            chk($sformatf("col_sel[%0d]", i), int'(col_sel), tbl[i].exp_col);
            pulse_len(m);
            chk($sformatf("pulse[%0d]", i), m, 4);
            chk($sformatf("hold[%0d]", i), int'({col_sel, busy}),
                tbl[i].exp_col * 2 + 1);
            jugador_actual = 2'd1;
            tick;
            chk($sformatf("ack_idle[%0d]", i), int'(busy), 0);
        end

        // All columns full: draw, no pulse, DONE is terminal
        do_reset(7'h7F, 1'b1);
        flag = 0;
        for (int i = 0; i < 23; i++) begin
            tick;
            if (!press_n || no_move) flag = 1;
        end
        chk("full_early", flag, 0);
        tick;
        chk("full_no_move", int'({no_move, busy, press_n}), 5);
        col_full = '0;
        flag = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (busy || !press_n) flag = 1;
        end
        chk("full_stays_done", flag, 0);

        // Winner flag on the 2nd PRESS cycle aborts the pulse
        do_reset(7'h00, 1'b1);
        wait_press(n);
        chk("abort_latency", n, 18);
        tick;
        chk("abort_pre", int'(press_n), 0);
        hay_ganador = 1'b1;
        #1;
        chk("abort_comb", int'(press_n), 1);
        tick;
        chk("abort_done", int'(busy), 0);
        hay_ganador = 1'b0;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (busy || !press_n) flag = 1;
        end
        chk("abort_stays_done", flag, 0);
        do_reset(7'h00, 1'b1);
        tick;
        chk("rst_leaves_done", int'(busy), 1);

        // enable dropped during THINK, then re-enabled
        do_reset(7'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick;
        enable = 1'b0;
        tick;
        chk("disable_think", int'(busy), 0);
        flag = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (!press_n || busy) flag = 1;
        end
        chk("disable_quiet", flag, 0);
        enable = 1'b1;
        tick;
        chk("reenable", int'(busy), 1);

        // Turn lost during SCAN: back to IDLE, no draw flagged
        do_reset(7'h7F, 1'b1);
        for (int i = 0; i < 18; i++) tick;
        chk("scan_busy", int'(busy), 1);
        jugador_actual = 2'd1;
        tick;
        chk("scan_turn_lost", int'(busy), 0);
        for (int i = 0; i < 10; i++) tick;
        chk("scan_no_draw", int'(no_move), 0);

        // Reset asserted mid-pulse releases press_n asynchronously
        do_reset(7'h00, 1'b1);
        wait_press(n);
        chk("midpulse_low", int'(press_n), 0);
        rst = 1'b1;
        #1;
        chk("midpulse_rst", int'({press_n, busy}), 2);
        tick;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
